exposure_sequencer: RTL

EXPOSURE_SEQUENCER -- requirements
Module: exposure_sequencer

---
 rtl/exposure_pkg.sv | 21 ++
 rtl/exposure_sequencer_ms_tick.sv | 34 +++
 rtl/exposure_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exposure_pkg.sv
// Shared types and constants for the exposure sequencer: FSM states, clamp limits
// and the per-channel power-on configuration.
package exposure_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        LOAD  = 3'd2,
        ON    = 3'd3,
        OFF   = 3'd4
    } state_t;

    localparam int TIME_MAX   = 9999;
    localparam int INT_MAX    = 100;

    localparam int DEF_ON_MS  = 3000;
    localparam int DEF_OFF_MS = 3000;
    localparam int DEF_REPS   = 1;
    localparam int DEF_INT    = 10;

endpackage

// File: rtl/exposure_sequencer_ms_tick.sv
// Restartable millisecond prescaler: tick pulses on every TICK-th enabled cycle,
// counted from the cycle in which clear is high (that cycle counts as position 0).
module ms_tick #(
    parameter int TICK = 16000
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_pos;

    // clear acts in the same cycle so a phase's first cycle is already position 0
    assign w_pos = clear ? '0 : r_cnt;
    assign tick  = en && (w_pos == CW'(TICK - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_pos + CW'(1);
        end else begin
            r_cnt <= w_pos;
        end
    end

endmodule

// File: rtl/exposure_sequencer.sv
// Multi-channel relay exposure sequencer: per-channel on/off/reps/intensity, intensity
// handshake before each channel. Optional freeze input enabled by EXPOSURE_PAUSE_EN.
module exposure_sequencer
    import exposure_pkg::*;
#(
    parameter int CLK_HZ = 16_000_000,
    parameter int N_CH   = 4,
    parameter int TIME_W = 14,
    parameter int INT_W  = 7,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [TIME_W-1:0] cfg_on_ms,
    input  logic [TIME_W-1:0] cfg_off_ms,
    input  logic [TIME_W-1:0] cfg_reps,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic              arm,
    input  logic              fire,
    input  logic              abort,
`ifdef EXPOSURE_PAUSE_EN
    input  logic              pause,
`endif
    output logic [N_CH-1:0]   relay,
    output logic [INT_W-1:0]  int_data,
    output logic              int_valid,
    input  logic              int_ready,
    output logic [2:0]        state,
    output logic [CH_W-1:0]   ch_active,
    output logic [TIME_W-1:0] rep_count,
    output logic              done
);

    localparam int                TICK  = CLK_HZ / 1000;
    localparam logic [TIME_W-1:0] T_MAX = TIME_W'(TIME_MAX);
    localparam logic [INT_W-1:0]  I_MAX = INT_W'(INT_MAX);

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [TIME_W-1:0] r_rep;
    logic [TIME_W-1:0] r_ms;
    logic              r_clr;
    logic              r_done;
    logic              r_int_valid;
    logic [INT_W-1:0]  r_int_data;
    logic [N_CH-1:0]   r_relay;

    logic [TIME_W-1:0] w_on   [N_CH];
    logic [TIME_W-1:0] w_off  [N_CH];
    logic [TIME_W-1:0] w_reps [N_CH];
    logic [INT_W-1:0]  w_int  [N_CH];
    logic [N_CH-1:0]   w_has_reps;
    logic              w_cfg_ok;
    logic              w_run;
    logic              w_tick;
    logic              w_phase_end;
    logic [TIME_W-1:0] w_dur;
    logic [N_CH-1:0]   w_onehot;
    logic              w_first_vld;
    logic [CH_W-1:0]   w_first_ch;
    logic              w_next_vld;
    logic [CH_W-1:0]   w_next_ch;

`ifdef EXPOSURE_PAUSE_EN
    assign w_run = ~pause;
`else
    assign w_run = 1'b1;
`endif

    assign w_cfg_ok = cfg_we && !abort && (r_state == IDLE || r_state == ARMED);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cfg
            logic [TIME_W-1:0] r_on;
            logic [TIME_W-1:0] r_off;
            logic [TIME_W-1:0] r_reps;
            logic [INT_W-1:0]  r_int;

            always_ff @(posedge CLK or negedge reset_n) begin
                if (!reset_n) begin
                    r_on   <= TIME_W'(DEF_ON_MS);
                    r_off  <= TIME_W'(DEF_OFF_MS);
                    r_reps <= TIME_W'(DEF_REPS);
                    r_int  <= INT_W'(DEF_INT);
                end else if (w_cfg_ok && cfg_ch == CH_W'(gi)) begin
                    r_on   <= (cfg_on_ms  > T_MAX) ? T_MAX : cfg_on_ms;
                    r_off  <= (cfg_off_ms > T_MAX) ? T_MAX : cfg_off_ms;
                    r_reps <= (cfg_reps   > T_MAX) ? T_MAX : cfg_reps;
                    r_int  <= (cfg_int    > I_MAX) ? I_MAX : cfg_int;
                end
            end

            assign w_on[gi]       = r_on;
            assign w_off[gi]      = r_off;
            assign w_reps[gi]     = r_reps;
            assign w_int[gi]      = r_int;
            assign w_has_reps[gi] = (r_reps != '0);
        end
    endgenerate

    // Descending scan so the lowest qualifying channel is the one left selected
    always_comb begin
        w_first_vld = 1'b0;
        w_first_ch  = '0;
        w_next_vld  = 1'b0;
        w_next_ch   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_has_reps[i]) begin
                w_first_vld = 1'b1;
                w_first_ch  = CH_W'(i);
                if (i > int'(r_ch)) begin
                    w_next_vld = 1'b1;
                    w_next_ch  = CH_W'(i);
                end
            end
        end
    end

    ms_tick #(.TICK(TICK)) u_ms_tick (
        .CLK     (CLK),
        .reset_n (reset_n),
        .clear   (r_clr),
        .en      (w_run),
        .tick    (w_tick)
    );

    assign w_onehot    = N_CH'(1) << r_ch;
    assign w_dur       = (r_state == OFF) ? w_off[r_ch] : w_on[r_ch];
    assign w_phase_end = w_run && ((w_dur == '0) || (w_tick && r_ms == w_dur - TIME_W'(1)));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_rep       <= '0;
            r_ms        <= '0;
            r_clr       <= 1'b0;
            r_done      <= 1'b0;
            r_int_valid <= 1'b0;
            r_int_data  <= '0;
            r_relay     <= '0;
        end else begin
            r_done <= 1'b0;
            r_clr  <= 1'b0;
            if (abort) begin
                r_state     <= IDLE;
                r_relay     <= '0;
                r_int_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (arm) r_state <= ARMED;
                    end
                    ARMED: begin
                        if (fire && w_first_vld) begin
                            r_state     <= LOAD;
                            r_ch        <= w_first_ch;
                            r_rep       <= '0;
                            r_int_valid <= 1'b1;
                            r_int_data  <= w_int[w_first_ch];
                        end else if (fire) begin
                            r_done <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (int_ready) begin
                            r_state     <= ON;
                            r_int_valid <= 1'b0;
                            r_clr       <= 1'b1;
                            r_ms        <= '0;
                            r_relay     <= (w_on[r_ch] != '0) ? w_onehot : '0;
                        end
                    end
                    ON: begin
                        if (w_phase_end) begin
                            r_state <= OFF;
                            r_clr   <= 1'b1;
                            r_ms    <= '0;
                            r_relay <= '0;
                        end else begin
                            if (w_tick) r_ms <= r_ms + TIME_W'(1);
                            r_relay <= w_run ? w_onehot : '0;
                        end
                    end
                    OFF: begin
                        if (w_phase_end) begin
                            r_ms  <= '0;
                            r_rep <= r_rep + TIME_W'(1);
                            if (r_rep + TIME_W'(1) < w_reps[r_ch]) begin
                                r_state <= ON;
                                r_clr   <= 1'b1;
                                r_relay <= (w_on[r_ch] != '0) ? w_onehot : '0;
                            end else if (w_next_vld) begin
                                r_state     <= LOAD;
                                r_ch        <= w_next_ch;
                                r_rep       <= '0;
                                r_int_valid <= 1'b1;
                                r_int_data  <= w_int[w_next_ch];
                            end else begin
                                r_state <= ARMED;
                                r_done  <= 1'b1;
                            end
                        end else if (w_tick) begin
                            r_ms <= r_ms + TIME_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign relay     = r_relay;
    assign int_data  = r_int_data;
    assign int_valid = r_int_valid;
    assign state     = r_state;
    assign ch_active = r_ch;
    assign rep_count = r_rep;
    assign done      = r_done;

endmodule
